// File: rtl/regfile_wb_ctrl.sv
// Register file write-port arbiter shared by the ALU and memory/long-op writebacks,
// with a one-entry memory holding buffer and a pending-long-write scoreboard for issue stalls.
module regfile_wb_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] issue_ra,
  input  logic [ADDR_WIDTH-1:0] issue_rb,
  output logic                  issue_stall,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_rd,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_rd,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  RegWr,
  output logic [ADDR_WIDTH-1:0] Rw,
  output logic [DATA_WIDTH-1:0] busW,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic                  buf_valid_reg;
  logic [ADDR_WIDTH-1:0] buf_rd_reg;
  logic [DATA_WIDTH-1:0] buf_data_reg;
  logic [AGE_W-1:0]      age_reg;
  logic [NUM_REGS-1:0]   busy_reg;

  logic                  mem_accept;
  logic                  sel_buf;
  logic                  sel_mem;
  logic                  wr_sel;
  logic [ADDR_WIDTH-1:0] wr_rd;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  starved;
  logic                  issue_set;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  assign mem_wb_ready = ~buf_valid_reg & ~reset;
  assign mem_accept   = mem_wb_valid & mem_wb_ready;
  assign sel_buf      = ~alu_wb_valid & buf_valid_reg;
  assign sel_mem      = ~alu_wb_valid & ~buf_valid_reg & mem_accept;

  always_comb begin
    wr_sel  = 1'b0;
    wr_rd   = alu_wb_rd;
    wr_data = alu_wb_data;
    if (alu_wb_valid) begin
      wr_sel = 1'b1;
    end else if (buf_valid_reg) begin
      wr_sel  = 1'b1;
      wr_rd   = buf_rd_reg;
      wr_data = buf_data_reg;
    end else if (mem_accept) begin
      wr_sel  = 1'b1;
      wr_rd   = mem_wb_rd;
      wr_data = mem_wb_data;
    end
  end

  assign starved     = (age_reg >= AGE_W'(STARVE_LIMIT));
  assign issue_stall = issue_valid &
                       (busy_reg[issue_ra] | busy_reg[issue_rb] | busy_reg[issue_rd] | starved);
  assign issue_set   = issue_valid & ~issue_stall & issue_long & (issue_rd != '0);

  // Set is applied after clear so a same-register set/clear leaves the bit set.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign set_vec[gi] = issue_set & (issue_rd == ADDR_WIDTH'(gi));
    assign clr_vec[gi] = (sel_buf & (buf_rd_reg == ADDR_WIDTH'(gi))) |
                         (sel_mem & (mem_wb_rd == ADDR_WIDTH'(gi)));
  end

  assign busy = busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWr         <= 1'b0;
      Rw            <= '0;
      busW          <= '0;
      busy_reg      <= '0;
      buf_valid_reg <= 1'b0;
      buf_rd_reg    <= '0;
      buf_data_reg  <= '0;
      age_reg       <= '0;
    end else begin
      RegWr <= wr_sel & (wr_rd != '0);
      if (wr_sel) begin
        Rw   <= wr_rd;
        busW <= wr_data;
      end

      busy_reg <= (busy_reg & ~clr_vec) | set_vec;

      if (sel_buf) begin
        buf_valid_reg <= 1'b0;
      end else if (alu_wb_valid & mem_accept) begin
        buf_valid_reg <= 1'b1;
        buf_rd_reg    <= mem_wb_rd;
        buf_data_reg  <= mem_wb_data;
      end

      if (sel_buf || !buf_valid_reg) begin
        age_reg <= '0;
      end else if (!starved) begin
        age_reg <= age_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: expected register-file writes are queued at stimulus
// time and a negedge monitor pops and compares each write the DUT presents.
module tb_regfile_wb_ctrl;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_ra, issue_rb;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected actual Rw=%0d busW=0x%0h required=no write", Rw, busW);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (Rw !== w.rd || busW !== w.data) begin
          failures++;
          $display("FAIL wr_data actual Rw=%0d busW=0x%0h required Rw=%0d busW=0x%0h",
                   Rw, busW, w.rd, w.data);
        end else begin
          $display("ok   wr Rw=%0d busW=0x%0h", Rw, busW);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_ra = 0; issue_rb = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 1; mem_wb_rd = 5'd4; mem_wb_data = 32'h44;

    // Reset held two cycles with a memory result pending
    step(); step();
    chk("rst_regwr", 64'(RegWr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(mem_wb_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(mem_wb_ready), 64'd1);
    push(5'd4, 32'h44);
    step();
    mem_wb_valid = 0;

    // ALU writes, including one to register 0
    alu_wb_valid = 1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    step();
    chk("alu_regwr", 64'(RegWr), 64'd1);
    alu_wb_rd = 5'd0; alu_wb_data = 32'h1;
    step();
    chk("alu_rd0_regwr", 64'(RegWr), 64'd0);
    alu_wb_valid = 0;

    // Scoreboard RAW on r7
    issue_valid = 1; issue_long = 1; issue_rd = 5'd7; issue_ra = 0; issue_rb = 0;
    #1;
    chk("long_issue_stall", 64'(issue_stall), 64'd0);
    step();
    issue_long = 0; issue_rd = 5'd8; issue_ra = 5'd7;
    #1;
    chk("busy7_set", 64'(busy[7]), 64'd1);
    chk("raw_stall0", 64'(issue_stall), 64'd1);
    step();
    chk("raw_stall1", 64'(issue_stall), 64'd1);
    mem_wb_valid = 1; mem_wb_rd = 5'd7; mem_wb_data = 32'h1234;
    push(5'd7, 32'h1234);
    #1;
    chk("raw_stall_clearing", 64'(issue_stall), 64'd1);
    step();
    mem_wb_valid = 0;
    #1;
    chk("busy7_clear", 64'(busy[7]), 64'd0);
    chk("raw_stall_drop", 64'(issue_stall), 64'd0);
    step();
    issue_valid = 0; issue_ra = 0;

    // ALU/memory conflict: mem buffered, second mem waits for drain
    alu_wb_valid = 1; alu_wb_rd = 5'd10; alu_wb_data = 32'hA0;
    mem_wb_valid = 1; mem_wb_rd = 5'd9; mem_wb_data = 32'hA5A5A5A5;
    push(5'd10, 32'hA0);
    #1;
    chk("cf_ready_c0", 64'(mem_wb_ready), 64'd1);
    step();
    alu_wb_rd = 5'd11; alu_wb_data = 32'hB1;
    mem_wb_rd = 5'd13; mem_wb_data = 32'hD3;
    push(5'd11, 32'hB1);
    #1;
    chk("cf_ready_c1", 64'(mem_wb_ready), 64'd0);
    step();
    alu_wb_rd = 5'd12; alu_wb_data = 32'hC2;
    push(5'd12, 32'hC2);
    #1;
    chk("cf_ready_c2", 64'(mem_wb_ready), 64'd0);
    step();
    alu_wb_valid = 0;
    push(5'd9, 32'hA5A5A5A5);
    #1;
    chk("cf_ready_c3", 64'(mem_wb_ready), 64'd0);
    step();
    push(5'd13, 32'hD3);
    chk("cf_ready_c4", 64'(mem_wb_ready), 64'd1);
    step();
    mem_wb_valid = 0;

    // Starvation: buffer held behind continuous ALU writes
    alu_wb_valid = 1; alu_wb_rd = 5'd1; alu_wb_data = 32'h100;
    mem_wb_valid = 1; mem_wb_rd = 5'd14; mem_wb_data = 32'hE;
    issue_valid = 1; issue_long = 0; issue_rd = 5'd2; issue_ra = 5'd3; issue_rb = 5'd4;
    push(5'd1, 32'h100);
    #1;
    chk("starve_stall_s0", 64'(issue_stall), 64'd0);
    step();
    mem_wb_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      alu_wb_data = 32'h100 + 32'(i);
      push(5'd1, alu_wb_data);
      #1;
      chk($sformatf("starve_stall_s%0d", i), 64'(issue_stall), (i >= 5) ? 64'd1 : 64'd0);
      if (i == 6) begin
        issue_valid = 0;
        #1;
        chk("starve_no_issue", 64'(issue_stall), 64'd0);
        issue_valid = 1;
      end
      step();
    end
    alu_wb_valid = 0;
    push(5'd14, 32'hE);
    #1;
    chk("starve_stall_drain", 64'(issue_stall), 64'd1);
    step();
    chk("starve_stall_drop", 64'(issue_stall), 64'd0);
    issue_valid = 0;

    // Reset with busy bit set and buffer full discards everything
    issue_valid = 1; issue_long = 1; issue_rd = 5'd3; issue_ra = 0; issue_rb = 0;
    #1;
    chk("rm_issue_stall", 64'(issue_stall), 64'd0);
    step();
    issue_valid = 0; issue_long = 0;
    alu_wb_valid = 1; alu_wb_rd = 5'd20; alu_wb_data = 32'h20;
    mem_wb_valid = 1; mem_wb_rd = 5'd15; mem_wb_data = 32'hF00D;
    push(5'd20, 32'h20);
    step();
    alu_wb_valid = 0; mem_wb_valid = 0;
    #1;
    chk("rm_busy3", 64'(busy[3]), 64'd1);
    chk("rm_ready_full", 64'(mem_wb_ready), 64'd0);
    reset = 1;
    step();
    chk("rm_busy_clr", 64'(busy), 64'd0);
    chk("rm_regwr", 64'(RegWr), 64'd0);
    reset = 0;
    #1;
    chk("rm_ready_after", 64'(mem_wb_ready), 64'd1);
    repeat (5) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
